// File: rtl/c5_fetch_unit_if.sv
// c5_fetch_unit_if: memory, redirect and decode handshake bundle of the c5 fetch stage
interface c5_fetch_unit_if #(parameter int WIDTH = 32);
  logic             mem_stb;
  logic [3:0]       mem_we;
  logic [31:0]      mem_adr;
  logic [WIDTH-1:0] mem_dat;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] instr;
  logic [31:0]      pc;
  logic             fault;
  modport master (
    output mem_stb, mem_we, mem_adr, valid, instr, pc, fault,
    input  mem_dat, redirect, redirect_pc, ready
  );
  modport slave (
    input  mem_stb, mem_we, mem_adr, valid, instr, pc, fault,
    output mem_dat, redirect, redirect_pc, ready
  );
endinterface

// File: rtl/c5_fetch_unit.sv
// c5_fetch_unit: fetch PC, 1-cycle memory read, 2-entry decode buffer, redirect kill (optional C5_FETCH_MISALIGN_TRAP_EN)
module c5_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WIDTH    = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  c5_fetch_unit_if.master  bus
);
  logic [31:0]      pc_next;
  logic [31:0]      infl_pc;
  logic             infl;
  logic [1:0]       occ;
  logic [WIDTH-1:0] b_instr [2];
  logic [31:0]      b_pc [2];
  logic             halted;
  logic             pop;
  logic             issue;
  logic             tail;
  logic [2:0]       credit;
  // issue only while buffered plus in-flight words after this cycle's pop leave room
  always_comb begin
    pop    = (occ != 2'd0) && bus.ready;
    credit = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    issue  = !I_rst && !bus.redirect && !halted && (credit < 3'd2);
    tail   = 1'(occ - {1'b0, pop});
  end
  assign bus.mem_stb = issue;
  assign bus.mem_we  = 4'b0000;
  assign bus.mem_adr = pc_next;
  assign bus.valid   = occ != 2'd0;
  assign bus.instr   = b_instr[0];
  assign bus.pc      = b_pc[0];
  // pc generation, in-flight tracking and head-shifting response buffer
  always_ff @(posedge I_clk)
    if (I_rst) begin
      pc_next <= RESET_PC;
      infl    <= 1'b0;
      infl_pc <= 32'd0;
      occ     <= 2'd0;
      b_instr <= '{default: '0};
      b_pc    <= '{default: '0};
    end else if (bus.redirect) begin
      pc_next <= bus.redirect_pc & ~32'd3;
      infl    <= 1'b0;
      occ     <= 2'd0;
    end else begin
      infl <= issue;
      occ  <= occ - {1'b0, pop} + {1'b0, infl};
      if (issue) begin
        pc_next <= pc_next + 32'd4;
        infl_pc <= pc_next;
      end
      if (pop) begin
        b_instr[0] <= b_instr[1];
        b_pc[0]    <= b_pc[1];
      end
      if (infl) begin
        b_instr[tail] <= bus.mem_dat;
        b_pc[tail]    <= infl_pc;
      end
    end
`ifdef C5_FETCH_MISALIGN_TRAP_EN
  // a misaligned redirect halts fetch and raises fault until an aligned redirect
  always_ff @(posedge I_clk)
    if (I_rst) halted <= 1'b0;
    else if (bus.redirect) halted <= |bus.redirect_pc[1:0];
  assign bus.fault = halted;
`else
  assign halted    = 1'b0;
  assign bus.fault = 1'b0;
`endif
endmodule

// File: tb/tb_c5_fetch_unit.sv
// tb_c5_fetch_unit: directed plus random checks of c5_fetch_unit against an issue-queue reference model
module tb_c5_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  typedef struct {
    logic [31:0] pc;
    int          t;
  } ent_t;
  logic I_clk = 1'b0;
  logic I_rst;
  c5_fetch_unit_if #(.WIDTH(32)) bus ();
  c5_fetch_unit #(.RESET_PC(RPC), .WIDTH(32)) dut (.I_clk(I_clk), .I_rst(I_rst), .bus(bus));
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_fault;
  bit          prev_rs;
  int          now;
  int          n_chk;
  int          n_fail;
  always #5 I_clk = ~I_clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction
  // instruction memory: one-cycle read latency, junk data when not strobed
  always @(posedge I_clk) bus.mem_dat <= bus.mem_stb ? f(bus.mem_adr) : $urandom;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, now);
    end
  endtask
  task automatic cyc(input bit r, input bit rd, input logic [31:0] rpc, input bit rs);
    bit ev, pop, iss;
    bus.ready = r;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    I_rst = rs;
    @(negedge I_clk);
    ev  = mq.size() > 0 && mq[0].t <= now;
    pop = ev && r;
    iss = !rs && !rd && !m_halt && (mq.size() - int'(pop)) < 2;
    chk("stb", 32'(bus.mem_stb), 32'(iss));
    chk("adr", bus.mem_adr, m_pc);
    chk("we", 32'(bus.mem_we), 32'd0);
    chk("valid", 32'(bus.valid), 32'(ev));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    if (ev) begin
      chk("pc", bus.pc, mq[0].pc);
      chk("instr", bus.instr, f(mq[0].pc));
    end
    if (prev_rs) begin
      chk("rst_pc", bus.pc, 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
    end
    if (rs) begin
      mq.delete();
      m_pc = RPC;
      m_halt = 0;
      m_fault = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (rd) begin
        mq.delete();
        m_pc = {rpc[31:2], 2'b00};
`ifdef C5_FETCH_MISALIGN_TRAP_EN
        m_halt = rpc[1:0] != 2'b00;
        m_fault = m_halt;
`endif
      end else if (iss) begin
        mq.push_back(ent_t'{m_pc, now + 2});
        m_pc += 32'd4;
      end
    end
    prev_rs = rs;
    now++;
    @(posedge I_clk);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    now = 0;
    m_pc = RPC;
    m_halt = 0;
    m_fault = 0;
    prev_rs = 1;
    I_rst = 1;
    bus.ready = 0;
    bus.redirect = 0;
    bus.redirect_pc = 0;
    repeat (2) @(posedge I_clk);
    #1;
    cyc(1, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h0000_0100, 0);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'hFFFF_FFF8, 0);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h0000_0102, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h0000_0200, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h0000_0300, 0);
    cyc(1, 1, 32'h0000_0400, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (5) cyc(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, a, $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
